// File: rtl/share_split_tx_if.sv
// share_split_tx_if: word handshake into the share splitter.
// master drives data_i/valid_i, slave returns ready_o.
interface share_split_tx_if #(
  parameter int W = 8
);
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o
  );
endinterface

// File: rtl/share_split_tx.sv
// share_split_tx: splits W-bit words into three serial shares
// (s1 = d^m, s2 = m^q one cycle later, r = q one cycle later).
// Ports: clk_i, rst_i (sync, active-high); up (data_i/valid_i/
// ready_o); seed_i/seed_load_i (LFSR seed, IDLE only);
// s1_o/s2_o/r_o shares; busy_o (SHIFT or TAIL); frame_o (bit 0).
// Macro SHARE_SPLIT_TX_FIXED_MASK_EN: masks forced to 0 (debug).
module share_split_tx #(
  parameter int          W        = 8,
  parameter logic [15:0] SEED_DEF = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  share_split_tx_if.slave   up,
  input  logic [15:0]       seed_i,
  input  logic              seed_load_i,
  output logic              s1_o,
  output logic              s2_o,
  output logic              r_o,
  output logic              busy_o,
  output logic              frame_o
);

  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          dv_q, dv_d;
  logic          dm_q, dm_d;
  logic          dr_q, dr_d;

  logic          rdy;
  logic          acc;
  logic          last;
  logic          m_k;
  logic          q_k;
  logic [15:0]   lfsr_nx;

  assign last = (idx_q == IW'(W - 1));
  assign rdy  = (state_q == IDLE) ||
                ((state_q == SHIFT) && last);
  assign acc  = up.valid_i && rdy;
  assign up.ready_o = rdy;

`ifdef SHARE_SPLIT_TX_FIXED_MASK_EN
  assign m_k = 1'b0;
  assign q_k = 1'b0;
`else
  assign m_k = lfsr_q[0];
  assign q_k = lfsr_q[1];
`endif

  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign lfsr_nx = {lfsr_q[0] ^ lfsr_q[2] ^
                    lfsr_q[3] ^ lfsr_q[5],
                    lfsr_q[15:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      lfsr_q  <= SEED_DEF;
      dv_q    <= 1'b0;
      dm_q    <= 1'b0;
      dr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      lfsr_q  <= lfsr_d;
      dv_q    <= dv_d;
      dm_q    <= dm_d;
      dr_q    <= dr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc) state_d = SHIFT;
      SHIFT:   if (last) state_d = acc ? SHIFT : TAIL;
      TAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d  = '0;
    sh_d   = sh_q;
    lfsr_d = lfsr_q;
    dv_d   = 1'b0;
    dm_d   = 1'b0;
    dr_d   = 1'b0;
    if (state_q == SHIFT) begin
      idx_d  = last ? '0 : idx_q + IW'(1);
      sh_d   = sh_q >> 1;
      lfsr_d = lfsr_nx;
      // s2/r of this bit go out one cycle after its s1.
      dv_d   = 1'b1;
      dm_d   = m_k ^ q_k;
      dr_d   = q_k;
    end
    if ((state_q == IDLE) && seed_load_i)
      lfsr_d = (seed_i == 16'h0) ? SEED_DEF : seed_i;
    if (acc)
      sh_d = up.data_i;
  end

  always_comb begin
    s1_o    = 1'b0;
    s2_o    = 1'b0;
    r_o     = 1'b0;
    busy_o  = 1'b0;
    frame_o = 1'b0;
    unique case (state_q)
      SHIFT: begin
        busy_o  = 1'b1;
        frame_o = (idx_q == '0);
        s1_o    = sh_q[0] ^ m_k;
        s2_o    = dv_q & dm_q;
        r_o     = dv_q & dr_q;
      end
      TAIL: begin
        busy_o = 1'b1;
        s2_o   = dv_q & dm_q;
        r_o    = dv_q & dr_q;
      end
      default: ;
    endcase
  end

endmodule
